tlc_multiway: RTL and testbench

//   N-direction traffic light controller with sensor-driven green arbitration.
//   - Per-direction min/max green, fixed yellow and all-red clearance, emergency preemption.
//   - Timing advances on a tick strobe, so lamp durations are independent of clk frequency.
//   - Top-level intersection controller; drives per-direction red/yellow/green lamp vectors.

---
 rtl/tlc_pkg.sv | 31 +++
 rtl/tlc_rr_pick.sv | 39 +++
 rtl/tlc_multiway.sv | 142 ++++++++++++++
 tb/tb_tlc_multiway.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared types and lamp decode for the intersection controllers.
// The two-way controller uses the same phase encoding and per-direction lamp rule.
package tlc_pkg;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2
    } phase_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    // Exactly one lamp per direction; only the owning direction can be non-red.
    function automatic lamp_t tlc_lamp(phase_t ph, logic is_cur);
        lamp_t l;
        l = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
        if (is_cur && ph == PH_GREEN) begin
            l.green = 1'b1;
            l.red   = 1'b0;
        end else if (is_cur && ph == PH_YELLOW) begin
            l.yellow = 1'b1;
            l.red    = 1'b0;
        end
        return l;
    endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin next-direction picker: first sensor set after cur_dir, wrapping,
// never returning cur_dir itself.
module tlc_rr_pick
    import tlc_pkg::*;
#(
    parameter  int NUM_DIRS = 4,
    localparam int DIR_W    = $clog2(NUM_DIRS)
) (
    input  logic [NUM_DIRS-1:0] sen,
    input  logic [DIR_W-1:0]    cur_dir,
    output logic                valid,
    output logic [DIR_W-1:0]    pick
);

    logic [DIR_W:0]      w_ofs;
    logic [NUM_DIRS-2:0] w_rot;
    logic [DIR_W:0]      w_sum;

    // Bit i of w_rot is direction cur_dir+1+i (mod NUM_DIRS); cur_dir itself drops off the top.
    assign w_ofs = {1'b0, cur_dir} + (DIR_W+1)'(1);
    assign w_rot = (NUM_DIRS-1)'({sen, sen} >> w_ofs);

    always_comb begin
        valid = 1'b0;
        pick  = '0;
        w_sum = '0;
        for (int i = NUM_DIRS - 2; i >= 0; i--) begin
            if (w_rot[i]) begin
                valid = 1'b1;
                w_sum = {1'b0, cur_dir} + (DIR_W+1)'(i + 1);
                if (w_sum >= (DIR_W+1)'(NUM_DIRS)) begin
                    w_sum = w_sum - (DIR_W+1)'(NUM_DIRS);
                end
                pick = w_sum[DIR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tlc_multiway.sv
// N-direction traffic light controller: tick-timed green/yellow/all-red phases,
// sensor-driven round-robin arbitration and emergency preemption.
module tlc_multiway
    import tlc_pkg::*;
#(
    parameter  int NUM_DIRS     = 4,
    parameter  int CNT_W        = 8,
    parameter  int MIN_GREEN    = 4,
    parameter  int MAX_GREEN    = 16,
    parameter  int YELLOW_TIME  = 2,
    parameter  int ALL_RED_TIME = 1,
    localparam int DIR_W        = $clog2(NUM_DIRS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [NUM_DIRS-1:0] sen,
    input  logic                preempt,
    input  logic [DIR_W-1:0]    preempt_dir,
    output logic [NUM_DIRS-1:0] green,
    output logic [NUM_DIRS-1:0] yellow,
    output logic [NUM_DIRS-1:0] red,
    output logic [DIR_W-1:0]    cur_dir,
    output phase_t              phase
);

    localparam logic [CNT_W:0] L_MIN  = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] L_MAX  = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0] L_YEL  = (CNT_W+1)'(YELLOW_TIME);
    localparam logic [CNT_W:0] L_ARED = (CNT_W+1)'(ALL_RED_TIME);
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if (NUM_DIRS < 2) begin : g_bad_dirs
        $error("tlc_multiway: NUM_DIRS must be >= 2");
    end
    if (MIN_GREEN < 1 || MIN_GREEN > MAX_GREEN) begin : g_bad_green
        $error("tlc_multiway: need 1 <= MIN_GREEN <= MAX_GREEN");
    end
    if (YELLOW_TIME < 1) begin : g_bad_yellow
        $error("tlc_multiway: YELLOW_TIME must be >= 1");
    end
    if (MAX_GREEN > CNT_MAX || YELLOW_TIME > CNT_MAX || ALL_RED_TIME > CNT_MAX) begin : g_bad_cnt
        $error("tlc_multiway: timing parameters must fit in CNT_W");
    end

    phase_t           r_phase;
    logic [DIR_W-1:0] r_cur_dir;
    logic [DIR_W-1:0] r_nxt_dir;
    logic [CNT_W-1:0] r_timer;

    logic             w_demand;
    logic [DIR_W-1:0] w_pick;
    logic [CNT_W:0]   w_tp1;
    logic [CNT_W-1:0] w_tmr_inc;
    logic             w_pre_ok;
    logic [DIR_W-1:0] w_nxt_eff;
    logic             w_gap;
    logic             w_max;

    tlc_rr_pick #(.NUM_DIRS(NUM_DIRS)) u_pick (
        .sen     (sen),
        .cur_dir (r_cur_dir),
        .valid   (w_demand),
        .pick    (w_pick)
    );

    assign w_tp1     = {1'b0, r_timer} + (CNT_W+1)'(1);
    assign w_tmr_inc = (&r_timer) ? r_timer : r_timer + CNT_W'(1);
    assign w_pre_ok  = preempt && ({1'b0, preempt_dir} < (DIR_W+1)'(NUM_DIRS));
    // A preempt arriving on the last yellow/all-red tick still steers the next green.
    assign w_nxt_eff = w_pre_ok ? preempt_dir : r_nxt_dir;
    assign w_gap     = w_demand && !sen[r_cur_dir] && (w_tp1 >= L_MIN);
    assign w_max     = w_demand && (w_tp1 >= L_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase   <= PH_GREEN;
            r_cur_dir <= '0;
            r_nxt_dir <= '0;
            r_timer   <= '0;
        end else if (tick) begin
            case (r_phase)
                PH_GREEN: begin
                    if (w_pre_ok) begin
                        // Preempted direction already green: hold with timer frozen.
                        if (preempt_dir != r_cur_dir) begin
                            r_phase   <= PH_YELLOW;
                            r_nxt_dir <= preempt_dir;
                            r_timer   <= '0;
                        end
                    end else if (w_gap || w_max) begin
                        r_phase   <= PH_YELLOW;
                        r_nxt_dir <= w_pick;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= w_tmr_inc;
                    end
                end
                PH_YELLOW: begin
                    r_nxt_dir <= w_nxt_eff;
                    if (w_tp1 == L_YEL) begin
                        r_timer <= '0;
                        if (ALL_RED_TIME > 0) begin
                            r_phase <= PH_ALL_RED;
                        end else begin
                            r_phase   <= PH_GREEN;
                            r_cur_dir <= w_nxt_eff;
                        end
                    end else begin
                        r_timer <= w_tmr_inc;
                    end
                end
                PH_ALL_RED: begin
                    r_nxt_dir <= w_nxt_eff;
                    if (w_tp1 == L_ARED) begin
                        r_timer   <= '0;
                        r_phase   <= PH_GREEN;
                        r_cur_dir <= w_nxt_eff;
                    end else begin
                        r_timer <= w_tmr_inc;
                    end
                end
                default: begin
                    r_phase <= PH_ALL_RED;
                    r_timer <= '0;
                end
            endcase
        end
    end

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_lamp
        lamp_t w_l;
        assign w_l       = tlc_lamp(r_phase, r_cur_dir == DIR_W'(d));
        assign green[d]  = w_l.green;
        assign yellow[d] = w_l.yellow;
        assign red[d]    = w_l.red;
    end

    assign cur_dir = r_cur_dir;
    assign phase   = r_phase;

endmodule

// File: tb/tb_tlc_multiway.sv
// Scenario bench for tlc_multiway at NUM_DIRS=4, MIN=4, MAX=16, YELLOW=2, ALL_RED=1.
// Expected observations are queued per clock and compared after each rising edge.
module tb_tlc_multiway;
    import tlc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] sen;
    logic       preempt;
    logic [1:0] preempt_dir;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
    logic [1:0] cur_dir;
    phase_t     phase;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    tlc_multiway #(
        .NUM_DIRS(4), .CNT_W(8), .MIN_GREEN(4), .MAX_GREEN(16),
        .YELLOW_TIME(2), .ALL_RED_TIME(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .sen         (sen),
        .preempt     (preempt),
        .preempt_dir (preempt_dir),
        .green       (green),
        .yellow      (yellow),
        .red         (red),
        .cur_dir     (cur_dir),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    // Expected {cur_dir, phase, green, yellow, red} for a given phase/owner.
    function automatic logic [15:0] ev(logic [1:0] ph, logic [1:0] d);
        logic [3:0] one;
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
        one = 4'b0001 << d;
        g = (ph == 2'd0) ? one : 4'b0000;
        y = (ph == 2'd1) ? one : 4'b0000;
        r = (ph == 2'd2) ? 4'b1111 : ~one;
        return {d, ph, g, y, r};
    endfunction

    function automatic logic [15:0] obs();
        return {cur_dir, phase, green, yellow, red};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(logic [1:0] ph, logic [1:0] d, int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ev(ph, d));
    endtask

    task automatic do_reset(logic [3:0] s);
        reset = 1'b1;
        tick = 1'b1;
        sen = s;
        preempt = 1'b0;
        preempt_dir = 2'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick = 1'b1;
        sen = 4'b0000;
        preempt = 1'b0;
        preempt_dir = 2'd0;
        #2;
        chk_cnt++;
        if (obs() !== ev(2'd0, 2'd0)) $display("FAIL reset_async got=%h exp=%h", obs(), ev(2'd0, 2'd0));
        else pass_cnt++;
        step();
        step();
        reset = 1'b0;
        push_run(2'd0, 2'd0, 50);
        for (int k = 0; k < 50; k++) begin
            step();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk_cnt++;
            if (obs() !== e) $display("FAIL rest_green cyc%0d got=%h exp=%h", k, obs(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_gap_out();
        do_reset(4'b0100);
        chk_cnt++;
        if (obs() !== ev(2'd0, 2'd0)) $display("FAIL gap_reset got=%h exp=%h", obs(), ev(2'd0, 2'd0));
        else pass_cnt++;
        push_run(2'd0, 2'd0, 3);
        push_run(2'd1, 2'd0, 2);
        push_run(2'd2, 2'd0, 1);
        push_run(2'd0, 2'd2, 4);
        push_run(2'd1, 2'd2, 2);
        push_run(2'd2, 2'd2, 1);
        push_run(2'd0, 2'd1, 2);
        for (int k = 0; k < 15; k++) begin
            step();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk_cnt++;
            if (obs() !== e) $display("FAIL gap_out cyc%0d got=%h exp=%h", k, obs(), e);
            else pass_cnt++;
            // Sensor swap during yellow must not disturb the latched next direction.
            if (k == 3) sen = 4'b0010;
        end
    endtask

    task automatic test_max_out();
        do_reset(4'b0011);
        chk_cnt++;
        if (obs() !== ev(2'd0, 2'd0)) $display("FAIL max_reset got=%h exp=%h", obs(), ev(2'd0, 2'd0));
        else pass_cnt++;
        push_run(2'd0, 2'd0, 15);
        push_run(2'd1, 2'd0, 2);
        push_run(2'd2, 2'd0, 1);
        push_run(2'd0, 2'd1, 3);
        for (int k = 0; k < 21; k++) begin
            step();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk_cnt++;
            if (obs() !== e) $display("FAIL max_out cyc%0d got=%h exp=%h", k, obs(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_rr_wrap_tick();
        logic [15:0] t_seq [16];
        for (int i = 0; i < 16; i++) begin
            if (i < 4)       t_seq[i] = ev(2'd0, 2'd0);
            else if (i < 6)  t_seq[i] = ev(2'd1, 2'd0);
            else if (i < 7)  t_seq[i] = ev(2'd2, 2'd0);
            else if (i < 11) t_seq[i] = ev(2'd0, 2'd3);
            else if (i < 13) t_seq[i] = ev(2'd1, 2'd3);
            else if (i < 14) t_seq[i] = ev(2'd2, 2'd3);
            else             t_seq[i] = ev(2'd0, 2'd0);
        end
        do_reset(4'b1000);
        chk_cnt++;
        if (obs() !== ev(2'd0, 2'd0)) $display("FAIL wrap_reset got=%h exp=%h", obs(), ev(2'd0, 2'd0));
        else pass_cnt++;
        for (int ed = 1; ed <= 45; ed++) exp_q.push_back(t_seq[ed / 3]);
        for (int ed = 1; ed <= 45; ed++) begin
            tick = (ed % 3 == 0);
            step();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk_cnt++;
            if (obs() !== e) $display("FAIL rr_wrap_tick edge%0d got=%h exp=%h", ed, obs(), e);
            else pass_cnt++;
            if (ed == 21) sen = 4'b0011;
        end
        tick = 1'b1;
    endtask

    task automatic test_preempt();
        do_reset(4'b0001);
        chk_cnt++;
        if (obs() !== ev(2'd0, 2'd0)) $display("FAIL pre_reset got=%h exp=%h", obs(), ev(2'd0, 2'd0));
        else pass_cnt++;
        push_run(2'd0, 2'd0, 1);
        push_run(2'd1, 2'd0, 2);
        push_run(2'd2, 2'd0, 1);
        push_run(2'd0, 2'd2, 24);
        push_run(2'd1, 2'd2, 2);
        push_run(2'd2, 2'd2, 1);
        push_run(2'd0, 2'd3, 6);
        push_run(2'd1, 2'd3, 1);
        for (int k = 0; k < 38; k++) begin
            step();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk_cnt++;
            if (obs() !== e) $display("FAIL preempt cyc%0d got=%h exp=%h", k, obs(), e);
            else pass_cnt++;
            if (k == 0)  begin preempt = 1'b1; preempt_dir = 2'd2; end
            if (k == 24) preempt = 1'b0;
            if (k == 28) begin preempt = 1'b1; preempt_dir = 2'd3; end
            if (k == 33) preempt = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset(4'b0100);
        chk_cnt++;
        if (obs() !== ev(2'd0, 2'd0)) $display("FAIL mid_reset0 got=%h exp=%h", obs(), ev(2'd0, 2'd0));
        else pass_cnt++;
        push_run(2'd0, 2'd0, 3);
        push_run(2'd1, 2'd0, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk_cnt++;
            if (obs() !== e) $display("FAIL mid_pre cyc%0d got=%h exp=%h", k, obs(), e);
            else pass_cnt++;
        end
        #3;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if (obs() !== ev(2'd0, 2'd0)) $display("FAIL mid_async got=%h exp=%h", obs(), ev(2'd0, 2'd0));
        else pass_cnt++;
        step();
        step();
        reset = 1'b0;
        push_run(2'd0, 2'd0, 3);
        push_run(2'd1, 2'd0, 2);
        push_run(2'd2, 2'd0, 1);
        push_run(2'd0, 2'd2, 2);
        for (int k = 0; k < 8; k++) begin
            step();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk_cnt++;
            if (obs() !== e) $display("FAIL mid_post cyc%0d got=%h exp=%h", k, obs(), e);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_gap_out();
        test_max_out();
        test_rr_wrap_tick();
        test_preempt();
        test_reset_mid();
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL queue_drain left=%0d exp=0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
